// File: rtl/klein_pkg.sv
// Shared definitions for the Klein accumulator: FSM state codes, format helpers
// and the sign-agnostic magnitude compare used to pick the Kahan/Babuska branch.
package klein_pkg;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] S_T   = 4'd1;
  localparam logic [3:0] S_D   = 4'd2;
  localparam logic [3:0] S_C   = 4'd3;
  localparam logic [3:0] S_T2  = 4'd4;
  localparam logic [3:0] S_D2  = 4'd5;
  localparam logic [3:0] S_CC  = 4'd6;
  localparam logic [3:0] S_CCS = 4'd7;
  localparam logic [3:0] OUT   = 4'd8;

  function automatic int unsigned fmt_bias(input int unsigned ew);
    return (32'd1 << (ew - 1)) - 32'd1;
  endfunction

  // All-ones exponent is a finite binade, so max finite is every magnitude bit set.
  function automatic logic [31:0] max_mag(input int unsigned ew, input int unsigned mw);
    return (32'd1 << (ew + mw)) - 32'd1;
  endfunction

  function automatic logic mag_ge(input logic [31:0] a, input logic [31:0] b,
                                  input int unsigned bw);
    logic [31:0] mask;
    mask = (32'd1 << (bw - 1)) - 32'd1;
    return (a & mask) >= (b & mask);
  endfunction

endpackage

// File: rtl/klein_fp_add.sv
// Combinational small-float adder: exact fixed-point sum, then RNE rounding
// with saturation to max finite; an exact zero result is always +0.
module klein_fp_add
  import klein_pkg::*;
#(
  parameter  int unsigned EXP_W  = 5,
  parameter  int unsigned MANT_W = 2,
  localparam int unsigned BW     = 1 + EXP_W + MANT_W
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          sub,
  output logic [BW-1:0] y
);

  // Every finite value is an integer multiple of the smallest subnormal.
  localparam int unsigned MW = MANT_W + (1 << EXP_W);
  localparam int unsigned SW = MW + 1;
  localparam int unsigned PW = $clog2(MW) + 1;
  localparam logic [MW-1:0] NORM_MIN = MW'(1) << (MANT_W + 1);
  localparam logic [PW-1:0] MANT_P   = PW'(MANT_W);
  localparam logic [PW-1:0] EXP_MAX  = PW'((1 << EXP_W) - 1);
  localparam logic [BW-2:0] MAX_MAG  = (BW-1)'(max_mag(EXP_W, MANT_W));

  function automatic logic [SW-1:0] to_fix(input logic [BW-1:0] v, input logic neg);
    logic [EXP_W-1:0] e;
    logic [SW-1:0]    m;
    e = v[BW-2 -: EXP_W];
    m = SW'({e != '0, v[MANT_W-1:0]});
    if (e != '0) m = m << (e - 1'b1);
    return neg ? (~m + 1'b1) : m;
  endfunction

  logic [SW-1:0]     sum;
  logic [MW-1:0]     mag, rem, half;
  logic [MANT_W-1:0] mant_r;
  logic [PW-1:0]     p, sh, ex;
  logic [BW-1:0]     rnd;
  logic [BW-2:0]     res;
  logic              neg, up;

  always_comb begin
    sum = to_fix(a, a[BW-1]) + to_fix(b, b[BW-1] ^ sub);
    neg = sum[SW-1];
    mag = neg ? MW'(~sum + 1'b1) : MW'(sum);
    p = '0;
    for (int i = 0; i < MW; i++) if (mag[i]) p = PW'(i);
    sh = '0; ex = '0; rem = '0; half = '0; mant_r = '0; up = 1'b0; rnd = '0;
    // Below the first normal binade the fixed-point value is the encoding itself.
    if (mag < NORM_MIN) begin
      res = mag[BW-2:0];
    end else begin
      sh     = p - MANT_P;
      mant_r = MANT_W'(mag >> sh);
      rem    = mag & ((MW'(1) << sh) - 1'b1);
      half   = MW'(1) << (sh - 1'b1);
      up     = (rem > half) || ((rem == half) && mant_r[0]);
      ex     = sh + 1'b1;
      rnd    = BW'({ex[EXP_W-1:0], mant_r}) + BW'(up);
      res    = (ex > EXP_MAX || rnd[BW-1]) ? MAX_MAG : rnd[BW-2:0];
    end
    y = (mag == '0) ? '0 : {neg, res};
  end

endmodule

// File: rtl/klein_accum.sv
// Streaming second-order Klein accumulator sharing one FP adder across 7 FSM steps.
// KLEIN_ACCUM_SKIP_ZERO_EN: retire +-0 elements in IDLE in a single cycle.
module klein_accum
  import klein_pkg::*;
#(
  parameter  int unsigned EXP_WIDTH_I  = 5,
  parameter  int unsigned MANT_WIDTH_I = 2,
  parameter  int unsigned CNT_WIDTH_I  = 16,
  localparam int unsigned BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [BIT_WIDTH_I-1:0] elem_i,
  input  logic                   elem_valid_i,
  input  logic                   elem_last_i,
  output logic                   elem_ready_o,
  output logic [BIT_WIDTH_I-1:0] sum_o,
  output logic [BIT_WIDTH_I-1:0] cs_o,
  output logic [BIT_WIDTH_I-1:0] ccs_o,
  output logic [CNT_WIDTH_I-1:0] cnt_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o
);

  logic [3:0]             state_q;
  logic [BIT_WIDTH_I-1:0] s_q, cs_q, ccs_q, x_q;
  logic [BIT_WIDTH_I-1:0] t_q, d_q, c_q;   // t/d/c reused for t2/d2/cc in second stage
  logic [CNT_WIDTH_I-1:0] cnt_q, cnt_inc;
  logic                   last_q;

  logic [BIT_WIDTH_I-1:0] add_a, add_b, add_y;
  logic                   add_sub, ge1, ge2;

  klein_fp_add #(.EXP_W(EXP_WIDTH_I), .MANT_W(MANT_WIDTH_I)) u_add (
    .a  (add_a),
    .b  (add_b),
    .sub(add_sub),
    .y  (add_y)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    ge1     = mag_ge(32'(s_q), 32'(x_q), BIT_WIDTH_I);
    ge2     = mag_ge(32'(cs_q), 32'(c_q), BIT_WIDTH_I);
    add_a   = s_q;
    add_b   = x_q;
    add_sub = 1'b0;
    case (state_q)
      S_D:   begin add_a = ge1 ? s_q : x_q;  add_b = t_q; add_sub = 1'b1; end
      S_C:   begin add_a = d_q;  add_b = ge1 ? x_q : s_q; end
      S_T2:  begin add_a = cs_q; add_b = c_q; end
      S_D2:  begin add_a = ge2 ? cs_q : c_q; add_b = t_q; add_sub = 1'b1; end
      S_CC:  begin add_a = d_q;  add_b = ge2 ? c_q : cs_q; end
      S_CCS: begin add_a = ccs_q; add_b = c_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      cs_q    <= '0;
      ccs_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      t_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (elem_valid_i) begin
          x_q     <= elem_i;
          last_q  <= elem_last_i;
          cnt_q   <= cnt_inc;
          state_q <= S_T;
`ifdef KLEIN_ACCUM_SKIP_ZERO_EN
          if (elem_i[BIT_WIDTH_I-2:0] == '0) state_q <= elem_last_i ? OUT : IDLE;
`endif
        end
        S_T:   begin t_q <= add_y; state_q <= S_D;  end
        S_D:   begin d_q <= add_y; state_q <= S_C;  end
        S_C:   begin c_q <= add_y; s_q <= t_q; state_q <= S_T2; end
        S_T2:  begin t_q <= add_y; state_q <= S_D2; end
        S_D2:  begin d_q <= add_y; state_q <= S_CC; end
        S_CC:  begin c_q <= add_y; cs_q <= t_q; state_q <= S_CCS; end
        S_CCS: begin ccs_q <= add_y; state_q <= last_q ? OUT : IDLE; end
        OUT: if (out_ready_i) begin
          s_q     <= '0;
          cs_q    <= '0;
          ccs_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign elem_ready_o = (state_q == IDLE);
  assign out_valid_o  = (state_q == OUT);
  assign busy_o       = (state_q != IDLE) && (state_q != OUT);
  assign sum_o        = s_q;
  assign cs_o         = cs_q;
  assign ccs_o        = ccs_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_klein_accum.sv
// Self-checking bench for klein_accum (E5M2): directed spec cases plus random sets
// checked against a real-arithmetic reference of the Klein recurrence.
module tb_klein_accum;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  elem_i = '0;
  logic        elem_valid_i = 1'b0;
  logic        elem_last_i = 1'b0;
  logic        elem_ready_o;
  logic [7:0]  sum_o, cs_o, ccs_o;
  logic [15:0] cnt_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        busy_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] m_s = '0, m_cs = '0, m_ccs = '0;
  int         m_cnt = 0;

`ifdef KLEIN_ACCUM_SKIP_ZERO_EN
  localparam int ZERO_SP = 1;
`else
  localparam int ZERO_SP = 8;
`endif

  klein_accum dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .elem_i(elem_i), .elem_valid_i(elem_valid_i),
    .elem_last_i(elem_last_i), .elem_ready_o(elem_ready_o), .sum_o(sum_o), .cs_o(cs_o),
    .ccs_o(ccs_o), .cnt_o(cnt_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic real p2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec(input logic [7:0] v);
    int  e;
    int  m;
    real r;
    e = int'(v[6:2]);
    m = int'(v[1:0]);
    if (e == 0) r = real'(m) * p2(-16);
    else r = real'(4 + m) * p2(e - 17);
    return v[7] ? -r : r;
  endfunction

  // Nearest representable magnitude, ties to even encoding; beyond range lands on max.
  function automatic logic [7:0] enc(input real v);
    real        mag, err, best_err;
    logic [7:0] best;
    mag = (v < 0.0) ? -v : v;
    best = '0;
    best_err = mag;
    for (int i = 1; i < 128; i++) begin
      err = dec(8'(i)) - mag;
      if (err < 0.0) err = -err;
      if (err < best_err || (err == best_err && (i % 2 == 0))) begin
        best_err = err;
        best = 8'(i);
      end
    end
    if (best == 8'h00) return 8'h00;
    return (v < 0.0) ? (best | 8'h80) : best;
  endfunction

  function automatic logic [7:0] radd(input logic [7:0] a, input logic [7:0] b, input bit sub);
    return enc(dec(a) + (sub ? -dec(b) : dec(b)));
  endfunction

  task automatic model_clear();
    m_s = '0; m_cs = '0; m_ccs = '0; m_cnt = 0;
  endtask

  task automatic model_push(input logic [7:0] x);
    logic [7:0] t, d, c, t2, d2, cc;
    bit g, g2;
    t  = radd(m_s, x, 0);
    g  = (m_s[6:0] >= x[6:0]);
    d  = g ? radd(m_s, t, 1) : radd(x, t, 1);
    c  = radd(d, g ? x : m_s, 0);
    m_s = t;
    t2 = radd(m_cs, c, 0);
    g2 = (m_cs[6:0] >= c[6:0]);
    d2 = g2 ? radd(m_cs, t2, 1) : radd(c, t2, 1);
    cc = radd(d2, g2 ? c : m_cs, 0);
    m_cs = t2;
    m_ccs = radd(m_ccs, cc, 0);
    if (m_cnt < 65535) m_cnt++;
  endtask

  // ---------------- drivers (enter and leave on a negedge) ----------------
  task automatic send(input logic [7:0] x, input logic l, output int acc);
    bit ok;
    ok = 0;
    elem_i = x; elem_last_i = l; elem_valid_i = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (elem_ready_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: elem_ready_o=%b required 1 within 64 cycles", elem_ready_o);
      elem_valid_i = 1'b0;
      acc = cyc;
      return;
    end
    @(negedge clk_i);
    acc = cyc;
    elem_valid_i = 1'b0; elem_last_i = 1'b0;
    model_push(x);
  endtask

  task automatic get_out(input int hold, output int vcyc, output logic [7:0] os,
                         output logic [7:0] ocs, output logic [7:0] occs, output logic [15:0] ocnt);
    bit ok;
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      if (out_valid_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    vcyc = cyc;
    os = sum_o; ocs = cs_o; occs = ccs_o; ocnt = cnt_o;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL out_timeout: out_valid_o=%b required 1 within 64 cycles", out_valid_o);
      return;
    end
    n_chk++;
    if ({sum_o, cs_o, ccs_o, cnt_o} !== {m_s, m_cs, m_ccs, 16'(m_cnt)}) begin
      n_fail++;
      $display("FAIL triple: got s=%h cs=%h ccs=%h cnt=%0d required s=%h cs=%h ccs=%h cnt=%0d",
               sum_o, cs_o, ccs_o, cnt_o, m_s, m_cs, m_ccs, m_cnt);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      n_chk++;
      if ({sum_o, cs_o, ccs_o, cnt_o, out_valid_o, elem_ready_o} !== {os, ocs, occs, ocnt, 2'b10}) begin
        n_fail++;
        $display("FAIL out_hold: cycle %0d got s=%h cs=%h ccs=%h cnt=%0d v=%b r=%b required stable s=%h cs=%h ccs=%h cnt=%0d v=1 r=0",
                 h, sum_o, cs_o, ccs_o, cnt_o, out_valid_o, elem_ready_o, os, ocs, occs, ocnt);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    n_chk++;
    if ({cnt_o, sum_o, out_valid_o, elem_ready_o} !== {16'd0, 8'h00, 2'b01}) begin
      n_fail++;
      $display("FAIL out_release: got cnt=%0d s=%h v=%b r=%b required cnt=0 s=00 v=0 r=1",
               cnt_o, sum_o, out_valid_o, elem_ready_o);
    end
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    n_chk++;
    if ({sum_o, cs_o, ccs_o, cnt_o, out_valid_o, busy_o, elem_ready_o} !== {24'h0, 16'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_state: got s=%h cs=%h ccs=%h cnt=%0d v=%b busy=%b r=%b required all 0, r=1",
               sum_o, cs_o, ccs_o, cnt_o, out_valid_o, busy_o, elem_ready_o);
    end
    model_clear();
  endtask

  task automatic test_pair();
    int a1, a2, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h3C, 1'b0, a1);
    send(8'h3C, 1'b1, a2);
    get_out(0, v, s, c, cc, n);
    n_chk++;
    if ({s, c, cc, n} !== {8'h40, 8'h00, 8'h00, 16'd2}) begin
      n_fail++;
      $display("FAIL pair_values: got s=%h cs=%h ccs=%h cnt=%0d required 40 00 00 2", s, c, cc, n);
    end
    n_chk++;
    if (v - a2 !== 7) begin
      n_fail++;
      $display("FAIL pair_latency: got %0d edges required 7", v - a2);
    end
  endtask

  task automatic test_tie_even();
    int a, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h3C, 1'b0, a);
    send(8'h30, 1'b0, a);
    send(8'h30, 1'b1, a);
    get_out(0, v, s, c, cc, n);
    n_chk++;
    if ({s, c, cc, n} !== {8'h3C, 8'h34, 8'h00, 16'd3}) begin
      n_fail++;
      $display("FAIL tie_even: got s=%h cs=%h ccs=%h cnt=%0d required 3c 34 00 3", s, c, cc, n);
    end
  endtask

  task automatic test_out_hold();
    int a, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h44, 1'b0, a);
    send(8'hB1, 1'b1, a);
    get_out(5, v, s, c, cc, n);
  endtask

  task automatic test_reset_mid();
    int a, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h3C, 1'b0, a);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    n_chk++;
    if ({sum_o, cs_o, ccs_o, cnt_o, out_valid_o, busy_o, elem_ready_o} !== {24'h0, 16'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_mid: got s=%h cs=%h ccs=%h cnt=%0d v=%b busy=%b r=%b required all 0, r=1",
               sum_o, cs_o, ccs_o, cnt_o, out_valid_o, busy_o, elem_ready_o);
    end
    model_clear();
    send(8'h40, 1'b1, a);
    get_out(0, v, s, c, cc, n);
    n_chk++;
    if ({s, n} !== {8'h40, 16'd1}) begin
      n_fail++;
      $display("FAIL reset_mid_newset: got s=%h cnt=%0d required 40 1", s, n);
    end
  endtask

  task automatic test_zero();
    int a1, a2, a3, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h00, 1'b0, a1);
    send(8'h80, 1'b0, a2);
    send(8'h3C, 1'b1, a3);
    n_chk++;
    if ((a2 - a1 !== ZERO_SP) || (a3 - a2 !== ZERO_SP)) begin
      n_fail++;
      $display("FAIL zero_spacing: got %0d,%0d required %0d,%0d", a2 - a1, a3 - a2, ZERO_SP, ZERO_SP);
    end
    get_out(0, v, s, c, cc, n);
    n_chk++;
    if ({s, c, cc, n} !== {8'h3C, 8'h00, 8'h00, 16'd3}) begin
      n_fail++;
      $display("FAIL zero_values: got s=%h cs=%h ccs=%h cnt=%0d required 3c 00 00 3", s, c, cc, n);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3, b, v;
    logic [7:0] s, c, cc; logic [15:0] n;
    send(8'h55, 1'b0, a1);
    elem_valid_i = 1'b1; elem_i = 8'hC7;
    b = 0;
    for (int k = 0; k < 20; k++) begin
      if (elem_ready_o) break;
      if (busy_o) b++;
      @(negedge clk_i);
    end
    n_chk++;
    if (b !== 7) begin
      n_fail++;
      $display("FAIL busy_len: got %0d cycles required 7", b);
    end
    send(8'hC7, 1'b0, a2);
    n_chk++;
    if (a2 - a1 !== 8) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d required 8", a2 - a1);
    end
    send(8'h2B, 1'b1, a3);
    n_chk++;
    if (a3 - a2 !== 8) begin
      n_fail++;
      $display("FAIL b2b_spacing_last: got %0d required 8", a3 - a2);
    end
    get_out(0, v, s, c, cc, n);
  endtask

  task automatic test_random();
    int a, v, len;
    logic [7:0] s, c, cc; logic [15:0] n;
    for (int set = 0; set < 25; set++) begin
      len = int'($urandom_range(1, 6));
      for (int e = 0; e < len; e++)
        send(8'($urandom_range(0, 255)), (e == len - 1), a);
      get_out(int'($urandom_range(0, 2)), v, s, c, cc, n);
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_tie_even();
    test_out_hold();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
